ibox_issue_arbiter: RTL and testbench
=====================================

Name: ibox_issue_arbiter

Overview:
Shares one combinational integer execute unit (the Alpha integer box: shifter/ALU/compare/mask-extract-insert/zap datapath) between two issue requesters. It does four things:
- Arbitrates round-robin between the requesters.
- Registers the winning opcode and operands and holds them stable on the Ibox inputs for the op's execute latency.
- Applies a multi-cycle window to multiply-class ops (major opcode 6'h13).
- Returns the captured result on a single valid/ready response channel, tagged with the requester id.

Parameters:
- MUL_LAT, 4, execute cycles for opcode[12:7]==6'h13 (MULL/MULQ/UMULH and /V forms); legal range 1..15.
- ALU_LAT, 1, execute cycles for all other opcodes; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept.
- req0_opcode  in  13  {major[5:0], func[6:0]}.
- req0_a  in  64  Ra operand.
- req0_b  in  64  Rb or literal operand.
- req1_opcode  in  13  same as req0_opcode, requester 1.
- req1_a  in  64  same as req0_a, requester 1.
- req1_b  in  64  same as req0_b, requester 1.
- ibox_opcode  out  13  to Ibox opcode.
- ibox_a  out  64  to Ibox a.
- ibox_b  out  64  to Ibox b.
- ibox_result  in  64  from Ibox result.
- ibox_bloc  in  6  from Ibox bloc.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester that issued the op.
- rsp_result  out  64  captured ibox_result.
- rsp_bloc  out  6  captured ibox_bloc.
- busy  out  1  high in EXEC or RESP.

Behaviour:
Clocking and reset
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, prio=0, cnt=0, op registers (ibox_opcode/a/b) = 0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_bloc=0, busy=0.
- Reset asserted mid-operation aborts the in-flight op silently; no response is ever produced for it.

Handshakes
- Request transfer occurs on a cycle with req_valid[i] & req_ready[i].
- Requesters hold valid, opcode and operands stable until ready; the arbiter never drops a presented request.
- Response transfer occurs on a cycle with rsp_valid & rsp_ready.

Grant logic (combinational)
- Grant is permitted when state==IDLE, or when state==RESP & rsp_ready.
- If both req_valid bits are set, requester prio wins.
- If exactly one is set, that requester wins regardless of prio.
- req_ready is one-hot or zero; at most one bit high.
- req_ready does not depend on the losing requester's inputs.

Accept (clock edge with a granted transfer)
- Latch the winner's opcode/a/b into the op registers; latch winner id.
- prio <= ~winner.
- cnt <= (opcode[12:7]==6'h13) ? MUL_LAT-1 : ALU_LAT-1.
- state <= EXEC.

EXEC
- ibox_* outputs are driven only from the op registers and are stable for the whole window.
- If cnt!=0: cnt decrements.
- If cnt==0: rsp_result<=ibox_result, rsp_bloc<=ibox_bloc, rsp_id<=latched id, rsp_valid<=1, state<=RESP.
- Request latency: accept edge to first rsp_valid cycle = LAT+1 cycles (ALU op with defaults: accept at edge T, EXEC in cycle T+1, rsp_valid in cycle T+2).

RESP
- rsp_valid, rsp_id, rsp_result and rsp_bloc are held stable until rsp_ready.
- On the response transfer with a request granted in the same cycle: go directly to EXEC (back-to-back issue; throughput of one ALU op per 2 cycles).
- On the response transfer with no grant: rsp_valid<=0, state<=IDLE.
- rsp_valid=0 with rsp_ready=1 has no effect.

Outputs and opcodes
- busy = (state!=IDLE).
- ibox_* outputs retain their last values in IDLE; they are not cleared after each op.
- Opcodes are not decoded beyond the major-6'h13 check; unsupported opcodes still pass through the full LAT window.

Test Plan:
1. Assert reset 2 cycles, then idle with req_valid=0 -> every output 0, req_ready=2'b00, busy=0.
2. req0 ADDQ: opcode {6'h10,7'h20}, a=5, b=7 -> req_ready=2'b01 in the same cycle; rsp_valid 2 cycles after accept; rsp_result=12, rsp_id=0.
3. Both valid from reset: req0 ADDQ 1+1, req1 SUBQ {6'h10,7'h29} 10-3, with rsp_ready=1 -> responses in order (id0, 2) then (id1, 7). Then both re-presented -> req0 granted first again (prio returned to 0).
4. req1 MULQ {6'h13,7'h20}: a=3, b=64'hFFFF_FFFF_FFFF_FFFE -> ibox_opcode stable for exactly 4 cycles; rsp_valid 5 cycles after accept; rsp_result=64'hFFFF_FFFF_FFFF_FFFA, rsp_id=1.
5. rsp_ready=0 for 6 cycles during RESP, with req0 valid -> rsp_* stable, req_ready=0. When rsp_ready rises, req0 is accepted in the same cycle and the next rsp_valid appears 2 cycles later.
6. Assert reset during MULQ EXEC (second execute cycle) -> rsp_valid never rises for that op; state IDLE and prio 0 after release.

Source files
------------

// File: rtl/ibox_issue_arbiter.sv
// Round-robin issue arbiter in front of a shared combinational integer execute unit.
// Holds the winning op on the Ibox inputs for its execute window and returns a tagged response.
module ibox_issue_arbiter #(
    parameter int MUL_LAT = 4,
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [12:0] req0_opcode,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [12:0] req1_opcode,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic [12:0] ibox_opcode,
    output logic [63:0] ibox_a,
    output logic [63:0] ibox_b,
    input  logic [63:0] ibox_result,
    input  logic [5:0]  ibox_bloc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic [5:0]  rsp_bloc,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] ALU_CNT = 4'(ALU_LAT - 1);

    state_t      state;
    logic        prio;
    logic [3:0]  cnt;
    logic        op_id;

    logic        grant_ok;
    logic        grant;
    logic        winner;
    logic [12:0] win_opcode;
    logic [63:0] win_a;
    logic [63:0] win_b;

    // A new op may issue only when nothing is in flight or the pending response leaves this cycle.
    always_comb begin
        grant_ok   = (state == IDLE) || ((state == RESP) && rsp_ready);
        winner     = (&req_valid) ? prio : req_valid[1];
        grant      = grant_ok && (|req_valid);
        req_ready  = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
        win_opcode = winner ? req1_opcode : req0_opcode;
        win_a      = winner ? req1_a : req0_a;
        win_b      = winner ? req1_b : req0_b;
    end

    assign busy = (state != IDLE);

    // An accept overrides the RESP->IDLE fall-through, giving back-to-back issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            prio        <= 1'b0;
            cnt         <= 4'd0;
            op_id       <= 1'b0;
            ibox_opcode <= 13'd0;
            ibox_a      <= 64'd0;
            ibox_b      <= 64'd0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= 64'd0;
            rsp_bloc    <= 6'd0;
        end else begin
            case (state)
                IDLE: ;
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result <= ibox_result;
                        rsp_bloc   <= ibox_bloc;
                        rsp_id     <= op_id;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (grant) begin
                ibox_opcode <= win_opcode;
                ibox_a      <= win_a;
                ibox_b      <= win_b;
                op_id       <= winner;
                prio        <= ~winner;
                cnt         <= (win_opcode[12:7] == 6'h13) ? MUL_CNT : ALU_CNT;
                state       <= EXEC;
            end
        end
    end

endmodule

// File: tb/tb_ibox_issue_arbiter.sv
// Directed bench for ibox_issue_arbiter: per-cycle vector table plus hand-written
// sequences for multiply latency, response backpressure and mid-op reset.
module tb_ibox_issue_arbiter;

    localparam logic [12:0] ADDQ = {6'h10, 7'h20};
    localparam logic [12:0] SUBQ = {6'h10, 7'h29};
    localparam logic [12:0] MULQ = {6'h13, 7'h20};
    localparam logic [12:0] NOP  = 13'd0;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [12:0] req0_opcode;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic [12:0] req1_opcode;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic [12:0] ibox_opcode;
    logic [63:0] ibox_a;
    logic [63:0] ibox_b;
    logic [63:0] ibox_result;
    logic [5:0]  ibox_bloc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_result;
    logic [5:0]  rsp_bloc;
    logic        busy;

    int compared;
    int mismatched;

    typedef struct {
        logic        pre_reset;
        logic [1:0]  valid;
        logic [12:0] op0;
        logic [63:0] a0;
        logic [63:0] b0;
        logic [12:0] op1;
        logic [63:0] a1;
        logic [63:0] b1;
        logic        rdy;
        logic [1:0]  exp_ready;
        logic        exp_busy;
        logic        exp_valid;
        logic        exp_id;
        logic [63:0] exp_result;
        logic [5:0]  exp_bloc;
    } vec_t;

    vec_t vecs[$];

    ibox_issue_arbiter #(.MUL_LAT(4), .ALU_LAT(1)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req0_opcode(req0_opcode),
        .req0_a(req0_a),
        .req0_b(req0_b),
        .req1_opcode(req1_opcode),
        .req1_a(req1_a),
        .req1_b(req1_b),
        .ibox_opcode(ibox_opcode),
        .ibox_a(ibox_a),
        .ibox_b(ibox_b),
        .ibox_result(ibox_result),
        .ibox_bloc(ibox_bloc),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_result(rsp_result),
        .rsp_bloc(rsp_bloc),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared combinational Ibox: only the opcodes this bench issues.
    always_comb begin
        ibox_result = 64'd0;
        case (ibox_opcode)
            ADDQ:    ibox_result = ibox_a + ibox_b;
            SUBQ:    ibox_result = ibox_a - ibox_b;
            MULQ:    ibox_result = ibox_a * ibox_b;
            default: ibox_result = 64'd0;
        endcase
        ibox_bloc = ibox_a[5:0] ^ ibox_b[5:0];
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid   = v.valid;
        req0_opcode = v.op0;
        req0_a      = v.a0;
        req0_b      = v.b0;
        req1_opcode = v.op1;
        req1_a      = v.a1;
        req1_b      = v.b1;
        rsp_ready   = v.rdy;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vec_t v;
        reset       = 1'b0;
        req_valid   = 2'b00;
        rsp_ready   = 1'b0;
        req0_opcode = NOP;
        req0_a      = 64'd0;
        req0_b      = 64'd0;
        req1_opcode = NOP;
        req1_a      = 64'd0;
        req1_b      = 64'd0;
        compared    = 0;
        mismatched  = 0;

        // Single ADDQ from requester 0, ALU latency.
        vecs.push_back('{1'b1, 2'b01, ADDQ, 64'd5, 64'd7, NOP, 64'd0, 64'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 64'd0,  6'd0});
        vecs.push_back('{1'b0, 2'b00, ADDQ, 64'd5, 64'd7, NOP, 64'd0, 64'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 64'd0,  6'd0});
        vecs.push_back('{1'b0, 2'b00, ADDQ, 64'd5, 64'd7, NOP, 64'd0, 64'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 64'd12, 6'd2});
        vecs.push_back('{1'b0, 2'b00, ADDQ, 64'd5, 64'd7, NOP, 64'd0, 64'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 64'd0,  6'd0});
        // Both requesters from reset, then both again: round robin and back-to-back issue.
        for (int r = 0; r < 2; r++) begin
            vecs.push_back('{(r == 0), 2'b11, ADDQ, 64'd1, 64'd1, SUBQ, 64'd10, 64'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 64'd0, 6'd0});
            vecs.push_back('{1'b0,     2'b10, ADDQ, 64'd1, 64'd1, SUBQ, 64'd10, 64'd3, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 64'd0, 6'd0});
            vecs.push_back('{1'b0,     2'b10, ADDQ, 64'd1, 64'd1, SUBQ, 64'd10, 64'd3, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 64'd2, 6'd0});
            vecs.push_back('{1'b0,     2'b00, ADDQ, 64'd1, 64'd1, SUBQ, 64'd10, 64'd3, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 64'd0, 6'd0});
            vecs.push_back('{1'b0,     2'b00, ADDQ, 64'd1, 64'd1, SUBQ, 64'd10, 64'd3, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 64'd7, 6'd9});
        end
        vecs.push_back('{1'b0, 2'b00, NOP, 64'd0, 64'd0, NOP, 64'd0, 64'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 64'd0, 6'd0});

        // Reset state.
        doReset();
        @(negedge clk);
        checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("reset rsp_result", rsp_result, 64'd0);
        checkOutput("reset rsp_bloc", 64'(rsp_bloc), 64'd0);
        checkOutput("reset ibox_opcode", 64'(ibox_opcode), 64'd0);
        checkOutput("reset ibox_a", ibox_a, 64'd0);
        checkOutput("reset ibox_b", ibox_b, 64'd0);
        checkOutput("reset req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        nextCycle();

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.pre_reset) doReset();
            applyStimulus(v);
            @(negedge clk);
            checkOutput($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(v.exp_ready));
            checkOutput($sformatf("vec%0d busy", i), 64'(busy), 64'(v.exp_busy));
            checkOutput($sformatf("vec%0d rsp_valid", i), 64'(rsp_valid), 64'(v.exp_valid));
            if (v.exp_valid) begin
                checkOutput($sformatf("vec%0d rsp_id", i), 64'(rsp_id), 64'(v.exp_id));
                checkOutput($sformatf("vec%0d rsp_result", i), rsp_result, v.exp_result);
                checkOutput($sformatf("vec%0d rsp_bloc", i), 64'(rsp_bloc), 64'(v.exp_bloc));
            end
            nextCycle();
        end

        // MULQ from requester 1: four execute cycles with the op held, response on the fifth.
        req_valid   = 2'b10;
        req1_opcode = MULQ;
        req1_a      = 64'd3;
        req1_b      = 64'hFFFF_FFFF_FFFF_FFFE;
        rsp_ready   = 1'b1;
        @(negedge clk);
        checkOutput("mul accept req_ready", 64'(req_ready), 64'b10);
        nextCycle();
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("mul exec%0d busy", k), 64'(busy), 64'd1);
            checkOutput($sformatf("mul exec%0d rsp_valid", k), 64'(rsp_valid), 64'd0);
            checkOutput($sformatf("mul exec%0d ibox_opcode", k), 64'(ibox_opcode), 64'(MULQ));
            checkOutput($sformatf("mul exec%0d ibox_b", k), ibox_b, 64'hFFFF_FFFF_FFFF_FFFE);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("mul rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("mul rsp_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFA);
        checkOutput("mul rsp_id", 64'(rsp_id), 64'd1);
        checkOutput("mul rsp_bloc", 64'(rsp_bloc), 64'h3D);
        nextCycle();
        @(negedge clk);
        checkOutput("mul drained busy", 64'(busy), 64'd0);
        nextCycle();

        // Response backpressure with a waiting requester, then same-cycle reissue.
        req_valid   = 2'b01;
        req0_opcode = ADDQ;
        req0_a      = 64'd20;
        req0_b      = 64'd22;
        rsp_ready   = 1'b0;
        @(negedge clk);
        checkOutput("bp accept req_ready", 64'(req_ready), 64'b01);
        nextCycle();
        req_valid = 2'b00;
        @(negedge clk);
        checkOutput("bp exec busy", 64'(busy), 64'd1);
        nextCycle();
        req_valid = 2'b01;
        req0_a    = 64'd100;
        req0_b    = 64'd1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp hold%0d rsp_valid", k), 64'(rsp_valid), 64'd1);
            checkOutput($sformatf("bp hold%0d rsp_result", k), rsp_result, 64'd42);
            checkOutput($sformatf("bp hold%0d rsp_id", k), 64'(rsp_id), 64'd0);
            checkOutput($sformatf("bp hold%0d req_ready", k), 64'(req_ready), 64'd0);
            nextCycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp release req_ready", 64'(req_ready), 64'b01);
        checkOutput("bp release rsp_result", rsp_result, 64'd42);
        nextCycle();
        req_valid = 2'b00;
        @(negedge clk);
        checkOutput("bp reissue exec rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("bp reissue exec busy", 64'(busy), 64'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("bp reissue rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("bp reissue rsp_result", rsp_result, 64'd101);
        nextCycle();

        // Reset during the second MULQ execute cycle: op is dropped, priority returns to 0.
        req_valid   = 2'b01;
        req0_opcode = MULQ;
        req0_a      = 64'd2;
        req0_b      = 64'd3;
        @(negedge clk);
        checkOutput("abort accept req_ready", 64'(req_ready), 64'b01);
        nextCycle();
        req_valid = 2'b00;
        @(negedge clk);
        checkOutput("abort exec1 busy", 64'(busy), 64'd1);
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort exec2 rsp_valid", 64'(rsp_valid), 64'd0);
        nextCycle();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("abort after%0d rsp_valid", k), 64'(rsp_valid), 64'd0);
            checkOutput($sformatf("abort after%0d busy", k), 64'(busy), 64'd0);
            nextCycle();
        end
        req_valid   = 2'b11;
        req0_opcode = ADDQ;
        req0_a      = 64'd1;
        req0_b      = 64'd1;
        req1_opcode = SUBQ;
        req1_a      = 64'd10;
        req1_b      = 64'd3;
        @(negedge clk);
        checkOutput("abort prio req_ready", 64'(req_ready), 64'b01);
        nextCycle();
        req_valid = 2'b00;
        repeat (4) nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
